// File: rtl/mmio_sync_fifo_pkg.sv
// Shared types and sizing helpers for the MMIO write-payload FIFO.
package mmio_sync_fifo_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic almost_full;
        logic full;
        logic empty;
    } t_fifo_status;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mmio_sync_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module mmio_sync_fifo_mem #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/mmio_sync_fifo.sv
// Synchronous FIFO for MMIO write payloads with occupancy and sticky error flags.
// Define MMIO_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module mmio_sync_fifo
    import mmio_sync_fifo_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          rd_valid,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    input  logic                          clr_err,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = fifo_cnt_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             rd_acc;
    logic             wr_acc;
    logic             ovf_set;
    logic             udf_set;
    logic [WIDTH-1:0] mem_rdata;
    t_fifo_status     status;

    // Flags come only from registered state, so no enable-to-status combinational path exists.
    always_comb begin
        status             = '0;
        status.empty       = (count_reg == '0);
        status.full        = (count_reg == CNT_W'(DEPTH));
        status.almost_full = (int'(count_reg) >= AFULL_THRESH);
        status.overflow    = overflow_reg;
        status.underflow   = underflow_reg;
    end

    // flush swallows both requests: nothing is accepted and nothing is flagged.
    assign rd_acc  = rd_en && !status.empty && !flush;
    assign wr_acc  = wr_en && (!status.full || rd_acc) && !flush;
    assign ovf_set = wr_en && !wr_acc && !flush;
    assign udf_set = rd_en && status.empty && !flush;

    always_comb begin
        count_next = count_reg;
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!wr_acc && rd_acc) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (wr_acc) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (rd_acc) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                count_reg <= count_next;
            end
            // A set in the same cycle as clr_err wins.
            overflow_reg  <= ovf_set || (overflow_reg && !clr_err);
            underflow_reg <= udf_set || (underflow_reg && !clr_err);
        end
    end

    mmio_sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_reg),
        .wdata (wr_data),
        .raddr (rd_ptr_reg),
        .rdata (mem_rdata)
    );

`ifdef MMIO_SYNC_FIFO_FWFT_EN
    assign rd_data  = status.empty ? '0 : mem_rdata;
    assign rd_valid = !status.empty;
`else
    logic [WIDTH-1:0] rd_data_reg;
    logic             rd_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (rd_acc) rd_data_reg <= mem_rdata;
            rd_valid_reg <= rd_acc && !flush;
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
`endif

    assign count       = count_reg;
    assign full        = status.full;
    assign empty       = status.empty;
    assign almost_full = status.almost_full;
    assign overflow    = status.overflow;
    assign underflow   = status.underflow;

endmodule

// File: tb/tb_mmio_sync_fifo.sv
// Scoreboard bench for mmio_sync_fifo: stimulus queues expected pop data, a monitor compares it.
module tb_mmio_sync_fifo;

`ifdef MMIO_SYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_err = 1'b0;
    logic [63:0] wr_data = '0;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        overflow;
    logic        underflow;
    logic        mon_fire;

    int errors = 0;
    int checks = 0;
    logic [63:0] expq[$];

    always #5 clk = ~clk;

    mmio_sync_fifo #(
        .WIDTH        (64),
        .DEPTH        (8),
        .AFULL_THRESH (7)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .clr_err     (clr_err),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [63:0] d, input logic r, input logic f, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        clr_err = c;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic push(input logic [63:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
        $display("push %h -> count=%0d", d, count);
    endtask

    task automatic pop(input logic [63:0] e);
        expq.push_back(e);
        cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic push_pop(input logic [63:0] d, input logic [63:0] e);
        expq.push_back(e);
        cyc(1'b1, d, 1'b1, 1'b0, 1'b0);
        $display("push %h + pop -> count=%0d", d, count);
    endtask

    assign mon_fire = FWFT ? (rd_valid && rd_en) : rd_valid;

    // Monitor: every presented read word must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mon_fire) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd: got %h want no read", rd_data);
                end else begin
                    logic [63:0] e;
                    e = expq.pop_front();
                    chk("rd_data", rd_data, e);
                    $display("pop  %h (expected %h)", rd_data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_afull", 64'(almost_full), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_udf", 64'(underflow), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill 0x1..0x8
        for (int i = 1; i <= 8; i++) begin
            push(64'(i));
            if (i == 7) begin
                chk("fill7_afull", 64'(almost_full), 64'd1);
                chk("fill7_full", 64'(full), 64'd0);
            end
        end
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_empty", 64'(empty), 64'd0);

        // Overflow at full, then clear
        push(64'hDEAD);
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
        cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 64'(overflow), 64'd0);

        // Push and pop together at full
        push_pop(64'h9, 64'h1);
        chk("fullpp_count", 64'(count), 64'd8);
        chk("fullpp_ovf", 64'(overflow), 64'd0);
        for (int i = 2; i <= 9; i++) pop(64'(i));
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_count", 64'(count), 64'd0);

        // Underflow on empty with concurrent push: no bypass
        cyc(1'b1, 64'hA, 1'b1, 1'b0, 1'b0);
        $display("push 000000000000000a + pop on empty -> count=%0d", count);
        chk("udf_flag", 64'(underflow), 64'd1);
        chk("udf_count", 64'(count), 64'd1);
        chk("udf_rd_valid", 64'(rd_valid), 64'(FWFT));
        cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("udf_clr", 64'(underflow), 64'd0);
        pop(64'hA);

        // Steady state at count=3 across pointer wrap
        for (int i = 0; i < 3; i++) push(64'h100 + 64'(i));
        for (int k = 0; k < 20; k++) push_pop(64'h103 + 64'(k), 64'h100 + 64'(k));
        chk("wrap_count", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) pop(64'h114 + 64'(i));
        chk("wrap_empty", 64'(empty), 64'd1);

        // Flush overrides push and pop
        for (int i = 0; i < 5; i++) push(64'h200 + 64'(i));
        chk("preflush_count", 64'(count), 64'd5);
        cyc(1'b1, 64'h2FF, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_rd_valid", 64'(rd_valid), 64'd0);
        chk("flush_udf", 64'(underflow), 64'd0);
        push(64'h300);
        pop(64'h300);

        // Asynchronous reset between edges, with a sticky flag set beforehand
        for (int i = 0; i < 9; i++) push(64'h400 + 64'(i));
        chk("prerst_ovf", 64'(overflow), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_full", 64'(full), 64'd0);
        chk("arst_afull", 64'(almost_full), 64'd0);
        chk("arst_rd_valid", 64'(rd_valid), 64'd0);
        chk("arst_rd_data", rd_data, 64'd0);
        chk("arst_ovf", 64'(overflow), 64'd0);
        chk("arst_udf", 64'(underflow), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
